// File: rtl/dual_ad_preadder_pipe_pkg.sv
// Shared constants for the A/D pre-adder stage: INMODE bit positions, mode strings
// and a small depth helper used by the top level.
package dual_ad_preadder_pipe_pkg;

    localparam int IM_A1SEL = 0;
    localparam int IM_ZEROA = 1;
    localparam int IM_DEN   = 2;
    localparam int IM_SUB   = 3;

    localparam string MODE_DIRECT  = "DIRECT";
    localparam string MODE_CASCADE = "CASCADE";
    localparam string MODE_TRUE    = "TRUE";
    localparam string MODE_FALSE   = "FALSE";

    function automatic int pipeMax(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/dual_ad_preadder_pipe_reg.sv
// Generic register chain with shared clock enable and synchronous active-low reset.
// DEPTH=0 degenerates to a plain wire.
module dsp_pipe_reg #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_ni,
    input  logic         ce_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    if (DEPTH == 0) begin : g_wire
        logic unusedInputs;
        assign unusedInputs = &{1'b0, clk, rst_ni, ce_i};
        assign q_o = d_i;
    end else begin : g_regs
        logic [W-1:0] stage_q [DEPTH];

        always_ff @(posedge clk) begin
            if (!rst_ni) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            end else if (ce_i) begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/dual_ad_preadder_pipe.sv
// A/D input stage of the DSP slice: A register chain with cascade tap, D and INMODE
// registers, saturating pre-adder with optional AD register, and a matching valid tag.
module dual_ad_preadder_pipe
    import dual_ad_preadder_pipe_pkg::*;
#(
    parameter int    A_W       = 30,
    parameter int    D_W       = 25,
    parameter string A_INPUT   = "DIRECT",
    parameter int    AREG      = 1,
    parameter int    ACASCREG  = 1,
    parameter int    DREG      = 1,
    parameter int    ADREG     = 1,
    parameter int    INMODEREG = 1,
    parameter string USE_DPORT = "FALSE",
    parameter int    SATURATE  = 0,
    parameter int    BALANCE   = 0
) (
    input  logic           clk,
    input  logic           RST_N,
    input  logic           CEA1,
    input  logic           CEA2,
    input  logic           CED,
    input  logic           CEAD,
    input  logic           CEINMODE,
    input  logic [A_W-1:0] A,
    input  logic [A_W-1:0] ACIN,
    input  logic [D_W-1:0] D,
    input  logic [3:0]     INMODE,
    input  logic           valid_in,
    output logic [A_W-1:0] ACOUT,
    output logic [A_W-1:0] A_X,
    output logic [D_W-1:0] A_MULT,
    output logic           valid_out
);

    localparam bit CFG_BAD = (AREG > 2) || (AREG < 0) || (ACASCREG > AREG) || (ACASCREG < 0)
                           || (AREG == 2 && ACASCREG == 0) || (DREG > 1) || (ADREG > 1)
                           || (INMODEREG > 1) || (DREG < 0) || (ADREG < 0) || (INMODEREG < 0)
                           || (A_INPUT != MODE_DIRECT && A_INPUT != MODE_CASCADE)
                           || (USE_DPORT != MODE_TRUE && USE_DPORT != MODE_FALSE);

    if (CFG_BAD) begin : g_bad_cfg
        $error("dual_ad_preadder_pipe: illegal parameter combination");
    end

    localparam bit USE_D  = (USE_DPORT == MODE_TRUE);
    localparam bit BAL    = (BALANCE != 0) && USE_D;
    localparam int A_PAD  = (BAL && DREG > AREG) ? DREG - AREG : 0;
    localparam int D_PAD  = (BAL && AREG > DREG) ? AREG - DREG : 0;
    localparam int LAT    = USE_D ? ((BAL ? pipeMax(AREG, DREG) : AREG) + ADREG) : AREG;
    localparam int A1_DEP = (AREG >= 1) ? 1 : 0;
    localparam int A2_DEP = (AREG == 2) ? 1 : 0;

    logic [A_W-1:0] aSrc;
    logic [A_W-1:0] a1_q;
    logic [A_W-1:0] aFinal_q;
    logic [D_W-1:0] d_q;
    logic [3:0]     im_q;
    logic [D_W-1:0] aSel;
    logic [D_W-1:0] aBal_q;
    logic [D_W-1:0] dBal_q;
    logic [D_W-1:0] aop;
    logic [D_W-1:0] dop;
    logic [D_W:0]   aExt;
    logic [D_W:0]   dExt;
    logic [D_W:0]   sum;
    logic           overflow;
    logic [D_W-1:0] ad_d;
    logic [D_W-1:0] ad_q;

    assign aSrc = (A_INPUT == MODE_CASCADE) ? ACIN : A;

    dsp_pipe_reg #(.W(A_W), .DEPTH(A1_DEP)) uA1 (
        .clk(clk), .rst_ni(RST_N), .ce_i(CEA1), .d_i(aSrc), .q_o(a1_q));
    dsp_pipe_reg #(.W(A_W), .DEPTH(A2_DEP)) uA2 (
        .clk(clk), .rst_ni(RST_N), .ce_i(CEA2), .d_i(a1_q), .q_o(aFinal_q));
    dsp_pipe_reg #(.W(D_W), .DEPTH(DREG)) uD (
        .clk(clk), .rst_ni(RST_N), .ce_i(CED), .d_i(D), .q_o(d_q));
    dsp_pipe_reg #(.W(4), .DEPTH(INMODEREG)) uInmode (
        .clk(clk), .rst_ni(RST_N), .ce_i(CEINMODE), .d_i(INMODE), .q_o(im_q));

    assign ACOUT = (ACASCREG == 1 && AREG == 2) ? a1_q : aFinal_q;
    assign A_X   = aFinal_q;
    assign aSel  = im_q[IM_A1SEL] ? a1_q[D_W-1:0] : aFinal_q[D_W-1:0];

    // Balance pads are free-running so the shorter path never stalls behind a CE.
    dsp_pipe_reg #(.W(D_W), .DEPTH(A_PAD)) uAPad (
        .clk(clk), .rst_ni(RST_N), .ce_i(1'b1), .d_i(aSel), .q_o(aBal_q));
    dsp_pipe_reg #(.W(D_W), .DEPTH(D_PAD)) uDPad (
        .clk(clk), .rst_ni(RST_N), .ce_i(1'b1), .d_i(d_q), .q_o(dBal_q));

    always_comb begin
        aop      = im_q[IM_ZEROA] ? '0 : aBal_q;
        dop      = im_q[IM_DEN] ? dBal_q : '0;
        aExt     = {aop[D_W-1], aop};
        dExt     = {dop[D_W-1], dop};
        sum      = im_q[IM_SUB] ? (dExt - aExt) : (dExt + aExt);
        overflow = sum[D_W] ^ sum[D_W-1];
        if ((SATURATE != 0) && overflow) begin
            ad_d = sum[D_W] ? {1'b1, {(D_W-1){1'b0}}} : {1'b0, {(D_W-1){1'b1}}};
        end else begin
            ad_d = sum[D_W-1:0];
        end
    end

    dsp_pipe_reg #(.W(D_W), .DEPTH(ADREG)) uAd (
        .clk(clk), .rst_ni(RST_N), .ce_i(CEAD), .d_i(ad_d), .q_o(ad_q));

    assign A_MULT = USE_D ? ad_q : aop;

    dsp_pipe_reg #(.W(1), .DEPTH(LAT)) uValid (
        .clk(clk), .rst_ni(RST_N), .ce_i(1'b1), .d_i(valid_in), .q_o(valid_out));

endmodule

// File: tb/tb_dual_ad_preadder_pipe.sv
// Scoreboard bench for dual_ad_preadder_pipe: three configurations (default wrap,
// saturating, and balanced cascade) driven in lockstep and checked against a model.
module tb_dual_ad_preadder_pipe;

    typedef struct {
        logic [24:0] data;
        int          due;
    } exp_t;

    logic        clk;
    logic        rstN;
    logic        cea1;
    logic [29:0] a;
    logic [29:0] acin;
    logic [24:0] d;
    logic [3:0]  inmode;
    logic [3:0]  imB;
    logic        validIn;

    logic [29:0] acout0, ax0, acout1, ax1, acout2, ax2;
    logic [24:0] amult0, amult1, amult2;
    logic        vout0, vout1, vout2;

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        q2[$];
    logic [29:0] acinHist[$];
    int          cyc;
    int          vecCount;
    int          missCount;
    logic [29:0] ax0Seen;

    dual_ad_preadder_pipe #(.USE_DPORT("TRUE")) dut0 (
        .clk(clk), .RST_N(rstN), .CEA1(cea1), .CEA2(1'b1), .CED(1'b1), .CEAD(1'b1),
        .CEINMODE(1'b1), .A(a), .ACIN(acin), .D(d), .INMODE(inmode), .valid_in(validIn),
        .ACOUT(acout0), .A_X(ax0), .A_MULT(amult0), .valid_out(vout0));

    dual_ad_preadder_pipe #(.USE_DPORT("TRUE"), .SATURATE(1)) dut1 (
        .clk(clk), .RST_N(rstN), .CEA1(1'b1), .CEA2(1'b1), .CED(1'b1), .CEAD(1'b1),
        .CEINMODE(1'b1), .A(a), .ACIN(acin), .D(d), .INMODE(inmode), .valid_in(validIn),
        .ACOUT(acout1), .A_X(ax1), .A_MULT(amult1), .valid_out(vout1));

    dual_ad_preadder_pipe #(.A_INPUT("CASCADE"), .AREG(2), .ACASCREG(1), .DREG(0),
                            .BALANCE(1), .USE_DPORT("TRUE")) dut2 (
        .clk(clk), .RST_N(rstN), .CEA1(1'b1), .CEA2(1'b1), .CED(1'b1), .CEAD(1'b1),
        .CEINMODE(1'b1), .A(a), .ACIN(acin), .D(d), .INMODE(imB), .valid_in(validIn),
        .ACOUT(acout2), .A_X(ax2), .A_MULT(amult2), .valid_out(vout2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [24:0] modelPreadd(input logic [29:0] aVal, input logic [24:0] dVal,
                                                input logic [3:0] im, input bit sat);
        longint av, dv, s;
        av = im[1] ? 64'sd0 : longint'($signed(aVal[24:0]));
        dv = im[2] ? longint'($signed(dVal)) : 64'sd0;
        s  = im[3] ? (dv - av) : (dv + av);
        if (sat) begin
            if (s > 64'sd16777215) s = 64'sd16777215;
            else if (s < -64'sd16777216) s = -64'sd16777216;
        end
        return s[24:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic scoreOne(input string name, input logic vo, input logic [24:0] am,
                            inout exp_t q[$]);
        exp_t e;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            checkOutput({name, " valid"}, 64'(vo), 64'd1);
            checkOutput({name, " amult"}, 64'(am), 64'(e.data));
        end else begin
            checkOutput({name, " idle valid"}, 64'(vo), 64'd0);
        end
    endtask

    task automatic applyStimulus(input logic [29:0] aV, input logic [29:0] acinV,
                                 input logic [24:0] dV, input logic [3:0] imV,
                                 input logic vV, input logic ce1V);
        @(negedge clk);
        cyc++;
        ax0Seen = ax0;
        scoreOne("dut0", vout0, amult0, q0);
        scoreOne("dut1", vout1, amult1, q1);
        scoreOne("dut2", vout2, amult2, q2);
        if (acinHist.size() == 2) begin
            checkOutput("dut2 acout", 64'(acout2), 64'(acinHist[1]));
            checkOutput("dut2 a_x", 64'(ax2), 64'(acinHist[0]));
        end
        a       = aV;
        acin    = acinV;
        d       = dV;
        inmode  = imV;
        validIn = vV;
        cea1    = ce1V;
        if (vV) begin
            q0.push_back('{modelPreadd(aV, dV, imV, 1'b0), cyc + 2});
            q1.push_back('{modelPreadd(aV, dV, imV, 1'b1), cyc + 2});
            q2.push_back('{modelPreadd(acinV, dV, imB, 1'b0), cyc + 3});
        end
        acinHist.push_back(acinV);
        if (acinHist.size() > 2) void'(acinHist.pop_front());
    endtask

    task automatic resetAndCheck();
        @(negedge clk);
        rstN = 1'b0;
        cea1 = 1'b1;
        @(negedge clk);
        checkOutput("rst dut0 a_x", 64'(ax0), 64'd0);
        checkOutput("rst dut0 amult", 64'(amult0), 64'd0);
        checkOutput("rst dut0 valid", 64'(vout0), 64'd0);
        checkOutput("rst dut0 acout", 64'(acout0), 64'd0);
        checkOutput("rst dut2 acout", 64'(acout2), 64'd0);
        checkOutput("rst dut2 a_x", 64'(ax2), 64'd0);
        checkOutput("rst dut2 valid", 64'(vout2), 64'd0);
        rstN    = 1'b1;
        validIn = 1'b0;
        q0.delete();
        q1.delete();
        q2.delete();
        acinHist.delete();
    endtask

    task automatic randomStep(input int pctValid);
        applyStimulus(30'($urandom()), 30'($urandom()), 25'($urandom()), 4'($urandom()),
                      ($urandom_range(0, 99) < pctValid), 1'b1);
    endtask

    initial begin
        vecCount  = 0;
        missCount = 0;
        cyc       = 0;
        rstN      = 1'b0;
        cea1      = 1'b1;
        a         = 30'h2AAA_AAAA;
        acin      = 30'h1555_5555;
        d         = 25'h0AB_CDEF;
        inmode    = 4'b0100;
        imB       = 4'b0100;
        validIn   = 1'b1;

        resetAndCheck();

        applyStimulus(30'd3, 30'd11, 25'd5, 4'b0100, 1'b1, 1'b1);
        applyStimulus(30'd7, 30'd12, 25'd2, 4'b1100, 1'b1, 1'b1);
        applyStimulus(30'h155, 30'd13, 25'h0AA, 4'b0010, 1'b1, 1'b1);
        applyStimulus(30'd1, 30'd1, 25'h0FF_FFFF, 4'b0100, 1'b1, 1'b1);
        applyStimulus(30'd1, 30'h3FFF_FFFF, 25'h100_0000, 4'b1100, 1'b1, 1'b1);
        applyStimulus(30'h0FF_FFFF, 30'h0FF_FFFF, 25'h0FF_FFFF, 4'b0101, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) randomStep(70);
        for (int i = 0; i < 4; i++) applyStimulus(30'd0, 30'd0, 25'd0, 4'b0100, 1'b0, 1'b1);

        applyStimulus(30'h1234, 30'd5, 25'd0, 4'b0100, 1'b0, 1'b1);
        applyStimulus(30'h1111, 30'd6, 25'd0, 4'b0100, 1'b0, 1'b0);
        checkOutput("a1 loaded", 64'(ax0Seen), 64'h1234);
        applyStimulus(30'h2222, 30'd7, 25'd0, 4'b0100, 1'b0, 1'b0);
        checkOutput("a1 hold 1", 64'(ax0Seen), 64'h1234);
        applyStimulus(30'h3333, 30'd8, 25'd0, 4'b0100, 1'b0, 1'b0);
        checkOutput("a1 hold 2", 64'(ax0Seen), 64'h1234);
        applyStimulus(30'h4444, 30'd9, 25'd0, 4'b0100, 1'b0, 1'b1);
        checkOutput("a1 hold 3", 64'(ax0Seen), 64'h1234);
        applyStimulus(30'h5555, 30'd10, 25'd0, 4'b0100, 1'b0, 1'b1);
        checkOutput("a1 released", 64'(ax0Seen), 64'h4444);

        for (int i = 0; i < 10; i++) randomStep(80);
        for (int i = 0; i < 3; i++)
            applyStimulus(30'h3ABC_DEF0, 30'h1234_5678, 25'h155_5555, 4'b0100, 1'b1, 1'b1);
        resetAndCheck();
        for (int i = 0; i < 12; i++) randomStep(75);

        for (int i = 0; i < 8; i++) applyStimulus(30'd0, 30'd0, 25'd0, 4'b0100, 1'b0, 1'b1);
        checkOutput("drain dut0", 64'(q0.size()), 64'd0);
        checkOutput("drain dut1", 64'(q1.size()), 64'd0);
        checkOutput("drain dut2", 64'(q2.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
